alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational `alu` datapath between `NUM_REQ` requesters. Each requester issues an operation with a valid/ready handshake. The block registers the operands, drives the ALU for one cycle, and returns the registered result on a shared response channel tagged with the requester ID. It sits between the ALU and its clients, such as the integer pipeline, address-generation logic and a debug port. Only one operation is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width. Derived; do not override.
- `CNT_W`, 16: width of the completed-operation counter.

Ports (packed arrays, requester i occupies slice i):
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `req_valid`  in  `NUM_REQ`  Per-requester operation request.
- `req_ready`  out  `NUM_REQ`  Per-requester accept; at most one bit set (one-hot).
- `req_a`  in  `NUM_REQ*32`  Operand a.
- `req_b`  in  `NUM_REQ*32`  Operand b.
- `req_op`  in  `NUM_REQ*4`  ALU op code, same encoding as `alu`.
- `rsp_valid`  out  1  Response available.
- `rsp_ready`  in  1  Consumer accepts the response.
- `rsp_id`  out  `ID_W`  Requester that owns the response.
- `rsp_result`  out  32  ALU result.
- `rsp_zero`  out  1  ALU zero flag.
- `rsp_err`  out  1  Op code was not one of the defined codes (0000-0111).
- `busy`  out  1  State is not IDLE.
- `op_count`  out  `CNT_W`  Number of completed response handshakes; wraps.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is set, grant g is the first set bit at or after `rr_ptr`, searching upward and wrapping.
  - `req_ready[g]` = 1 combinationally; all other `req_ready` bits = 0.
  - On the handshake: latch a, b, op and g into operand registers, then go to EXEC.
  - If no `req_valid` is set: stay in IDLE, all `req_ready` = 0.
- EXEC:
  - ALU inputs come from the operand registers.
  - Latch `rsp_result`, `rsp_zero`, `rsp_id`, and `rsp_err` (= op[3]).
  - `rr_ptr` <= (g+1) mod `NUM_REQ`.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1; all response fields stay stable until `rsp_ready`.
  - On `rsp_ready`: increment `op_count` (wraps from 2^`CNT_W`-1 to 0), go to IDLE.
  - `req_ready` = 0 throughout RESP.
- Requesters may drop `req_valid` before their handshake. The grant is recomputed every IDLE cycle and no starvation state is kept beyond `rr_ptr`.
- Undefined op codes: the result is whatever `alu` returns (0, with `rsp_zero` = 1), and `rsp_err` = 1.
- Arithmetic is exactly that of `alu`: 32-bit wrap-around add/sub, unsigned compare for SLT, shift amount b[4:0].

## Timing
- Reset values (asynchronous): state IDLE, `rr_ptr` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_zero` = 0, `rsp_err` = 0, `busy` = 0, `op_count` = 0.
- Latency: request handshake in cycle T gives `rsp_valid` = 1 in cycle T+2.
- Best-case throughput: one operation per 3 cycles, with `rsp_ready` tied high.
- Back-pressure: `rsp_ready` low holds RESP indefinitely; no new grants are issued meanwhile.
- Simultaneous requests: exactly one grant per IDLE cycle. After serving g, requester g has the lowest priority.
- Reset asserted mid-operation: the in-flight transaction is discarded, no response is produced, and `op_count` is not incremented.
- `req_ready` depends combinationally on `req_valid`. All response outputs and `busy` are registered.

## Structure
- Shared package (`alu_pkg`) holds:
  - the op-code localparams (`ALU_ADD` .. `ALU_SRL`);
  - the `alu_op_t` 4-bit type;
  - the FSM state enum `arb_state_t`.
- Sub-module `rr_arbiter`: parameterized `NUM_REQ`. Inputs are the request vector and `rr_ptr`; outputs are the one-hot grant and its encoded index. Purely combinational.
- Instantiates the existing `alu` unchanged.

## Test plan
- Single request, requester 2: a=5, b=3, op=0001 → `req_ready[2]` in the same cycle; 2 cycles later `rsp_valid` = 1, `rsp_id` = 2, `rsp_result` = 2, `rsp_zero` = 0, `rsp_err` = 0.
- All 4 requesters held valid continuously, `rsp_ready` = 1 → grant order 0, 1, 2, 3, 0; a response every 3 cycles; `op_count` = 5 after 5 responses.
- a=7, b=7, op=0001 → `rsp_result` = 0, `rsp_zero` = 1. Op=1010 → `rsp_result` = 0, `rsp_zero` = 1, `rsp_err` = 1.
- `rsp_ready` held low for 10 cycles while `req_valid[1]` = 1 → response fields stable, `req_ready` = 0 throughout; `req_ready[1]` is granted 1 cycle after the response handshake.
- `rst_n` pulsed low during EXEC → all outputs return to reset values immediately; no response after release; `op_count` stays 0.
- `op_count` preset by driving 65535 responses (or forced) → the next handshake wraps it to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin front-end arbiter.
//   - op-code encoding (alu_op_t, ALU_ADD .. ALU_SRL)
//   - datapath widths
//   - arbiter FSM state encoding (arb_state_t)
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'b0000;
    localparam alu_op_t ALU_SUB = 4'b0001;
    localparam alu_op_t ALU_AND = 4'b0010;
    localparam alu_op_t ALU_OR  = 4'b0011;
    localparam alu_op_t ALU_XOR = 4'b0100;
    localparam alu_op_t ALU_SLT = 4'b0101;
    localparam alu_op_t ALU_SLL = 4'b0110;
    localparam alu_op_t ALU_SRL = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU.
//   i_a, i_b     : 32-bit operands
//   i_op         : operation code (alu_op_t)
//   o_result_c   : result; 0 for undefined op codes
//   o_zero_c     : result == 0
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_t           i_op,
    output logic [DATA_W-1:0] o_result_c,
    output logic              o_zero_c
);

    // Operation decode; SLT is an unsigned compare, shifts use b[4:0]
    always_comb begin
        o_result_c = '0;
        case (i_op)
            ALU_ADD: o_result_c = i_a + i_b;
            ALU_SUB: o_result_c = i_a - i_b;
            ALU_AND: o_result_c = i_a & i_b;
            ALU_OR:  o_result_c = i_a | i_b;
            ALU_XOR: o_result_c = i_a ^ i_b;
            ALU_SLT: o_result_c = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            ALU_SLL: o_result_c = i_a << i_b[4:0];
            ALU_SRL: o_result_c = i_a >> i_b[4:0];
            default: o_result_c = '0;
        endcase
    end

    assign o_zero_c = (o_result_c == '0);

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin grant: first set request at or above i_ptr,
// searching upward with wrap-around.
//   i_req        : request vector
//   i_ptr        : highest-priority index
//   o_gnt_c      : one-hot grant (all zero when no request)
//   o_gnt_idx_c  : encoded grant index
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [ID_W-1:0]    o_gnt_idx_c
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Rotating priority scan starting at the pointer
    always_comb begin
        o_gnt_c     = '0;
        o_gnt_idx_c = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_gnt_c[w_idx] = 1'b1;
                o_gnt_idx_c    = w_idx;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU among NUM_REQ requesters.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot, comb)
//   req_a/req_b/req_op  : packed per-requester operands, slice i = requester i
//   rsp_*               : registered response channel tagged with requester id
//   busy                : registered, state not IDLE
//   op_count            : completed response handshakes, wraps
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    arb_state_t         r_state, w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr, r_gid;
    logic [DATA_W-1:0]  r_a, r_b;
    alu_op_t            r_op;
    logic               r_rsp_valid, r_rsp_zero, r_rsp_err, r_busy;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_result;
    logic [CNT_W-1:0]   r_op_count;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [DATA_W-1:0]  w_sel_a, w_sel_b, w_alu_result;
    alu_op_t            w_sel_op;
    logic               w_alu_zero;
    logic               w_accept, w_exec, w_rsp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_gnt_c     (w_gnt),
        .o_gnt_idx_c (w_gnt_idx)
    );

    alu u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_result_c (w_alu_result),
        .o_zero_c   (w_alu_zero)
    );

    // Operand mux for the granted requester
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = ALU_ADD;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
                w_sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake strobes; a grant is only offered in IDLE
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready   = w_gnt;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, result capture, pointer advance and completion count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_gid        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= ALU_ADD;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_op  <= w_sel_op;
                r_gid <= w_gnt_idx;
            end
            if (w_exec) begin
                r_rsp_result <= w_alu_result;
                r_rsp_zero   <= w_alu_zero;
                r_rsp_id     <= r_gid;
                r_rsp_err    <= r_op[OP_W-1];
                // Served requester drops to lowest priority
                if (r_gid == ID_W'(NUM_REQ-1)) r_rr_ptr <= '0;
                else                           r_rr_ptr <= r_gid + ID_W'(1);
            end
            if (w_rsp_done) r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// round-robin, back-pressure, mid-operation reset and counter-wrap sequences.
// A second instance with a 3-bit counter exercises the op_count wrap.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready, req_ready_w;
    logic [NR*32-1:0]     req_a, req_b;
    logic [NR*4-1:0]      req_op;
    logic                 rsp_valid, rsp_valid_w;
    logic                 rsp_ready;
    logic [IW-1:0]        rsp_id, rsp_id_w;
    logic [31:0]          rsp_result, rsp_result_w;
    logic                 rsp_zero, rsp_zero_w, rsp_err, rsp_err_w;
    logic                 busy, busy_w;
    logic [15:0]          op_count;
    logic [2:0]           op_count_w;

    int          n_chk;
    int          n_fail;
    int unsigned exp_cnt;

    alu_arbiter #(.NUM_REQ(NR), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.NUM_REQ(NR), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid_w),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id_w), .rsp_result(rsp_result_w),
        .rsp_zero(rsp_zero_w), .rsp_err(rsp_err_w), .busy(busy_w), .op_count(op_count_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    // One isolated transaction from requester id, checked end to end
    task automatic run_op(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] res,
                          input logic z, input logic e);
        @(negedge clk);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*4 +: 4]  = op;
        req_valid          = 4'(1) << id;
        #1;
        chk("grant", 32'(req_ready), 32'(1) << id);
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("ready_exec", 32'(req_ready), 32'd0);
        chk("valid_exec", 32'(rsp_valid), 32'd0);
        chk("busy_exec", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), id);
        chk("rsp_result", rsp_result, res);
        chk("rsp_zero", 32'(rsp_zero), 32'(z));
        chk("rsp_err", 32'(rsp_err), 32'(e));
        chk("w_rsp_valid", 32'(rsp_valid_w), 32'd1);
        chk("w_rsp_id", 32'(rsp_id_w), id);
        chk("w_rsp_result", rsp_result_w, res);
        chk("w_flags", {30'd0, rsp_zero_w, rsp_err_w}, {30'd0, z, e});
        chk("w_busy", {30'd0, busy_w, |req_ready_w}, 32'd2);
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        rsp_ready = 1'b0;
        #1;
        chk("valid_done", 32'(rsp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("op_count", 32'(op_count), exp_cnt & 32'hffff);
        chk("op_count_w", 32'(op_count_w), exp_cnt % 8);
    endtask

    typedef struct {
        int unsigned id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs[12];
    int   order[5];

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;

        vecs[0]  = '{2, 32'd5,          32'd3,          ALU_SUB, 32'd2,          1'b0, 1'b0};
        vecs[1]  = '{0, 32'd7,          32'd7,          ALU_SUB, 32'd0,          1'b1, 1'b0};
        vecs[2]  = '{1, 32'd1,          32'd2,          4'b1010, 32'd0,          1'b1, 1'b1};
        vecs[3]  = '{3, 32'hffff_ffff,  32'd1,          ALU_ADD, 32'd0,          1'b1, 1'b0};
        vecs[4]  = '{0, 32'hf0f0_00ff,  32'h0ff0_0f0f,  ALU_AND, 32'h00f0_000f,  1'b0, 1'b0};
        vecs[5]  = '{1, 32'h0000_1200,  32'h0000_0034,  ALU_OR,  32'h0000_1234,  1'b0, 1'b0};
        vecs[6]  = '{2, 32'hffff_0000,  32'hff00_ff00,  ALU_XOR, 32'h00ff_ff00,  1'b0, 1'b0};
        vecs[7]  = '{3, 32'd1,          32'd2,          ALU_SLT, 32'd1,          1'b0, 1'b0};
        vecs[8]  = '{0, 32'hffff_ffff,  32'd1,          ALU_SLT, 32'd0,          1'b1, 1'b0};
        vecs[9]  = '{1, 32'd1,          32'h0000_0024,  ALU_SLL, 32'h0000_0010,  1'b0, 1'b0};
        vecs[10] = '{2, 32'h8000_0000,  32'd31,         ALU_SRL, 32'd1,          1'b0, 1'b0};
        vecs[11] = '{3, 32'd3,          32'd5,          ALU_SUB, 32'hffff_fffe,  1'b0, 1'b0};
        order    = '{0, 1, 2, 3, 0};

        // Asynchronous reset values before any clock edge
        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_id_flags", {29'd0, rsp_id, rsp_zero}, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        do_reset();

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].z, vecs[i].e);

        // All requesters valid, rsp_ready high: grants 0,1,2,3,0 every 3 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 1);
            req_b[i*32 +: 32] = 32'd0;
            req_op[i*4 +: 4]  = ALU_ADD;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 4'hf;
        begin
            int k, r, last;
            k = 0; r = 0; last = 0;
            for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
                #1;
                if (req_ready != '0) begin
                    chk("rr_grant", 32'(req_ready), 32'(1) << order[k]);
                    if (k > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
                    last = cyc;
                    k++;
                end
                if (rsp_valid) begin
                    chk("rr_rsp_id", 32'(rsp_id), 32'(order[r]));
                    chk("rr_rsp_result", rsp_result, 32'(order[r] + 1));
                    r++;
                    exp_cnt++;
                end
                @(negedge clk);
            end
            chk("rr_grants_seen", 32'(k), 32'd5);
            req_valid = '0;
            #1;
            chk("rr_ready_exec", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_last_valid", 32'(rsp_valid), 32'd1);
            chk("rr_last_id", 32'(rsp_id), 32'd0);
            if (rsp_valid) begin
                r++;
                exp_cnt++;
            end
            @(negedge clk);
            #1;
            chk("rr_rsp_seen", 32'(r), 32'd5);
            chk("rr_op_count", 32'(op_count), 32'd5);
            chk("rr_idle", {30'd0, rsp_valid, busy}, 32'd0);
        end
        rsp_ready = 1'b0;

        // Back-pressure: rsp_ready low for 10 cycles with requester 1 waiting
        @(negedge clk);
        req_a[32 +: 32] = 32'd10;
        req_b[32 +: 32] = 32'd20;
        req_op[4 +: 4]  = ALU_ADD;
        req_valid       = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'd2);
        @(negedge clk);
        #1;
        chk("bp_ready_exec", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_result", rsp_result, 32'd30);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_result", rsp_result, 32'd30);
            chk("bp_hold_id", {29'd0, rsp_id, rsp_err}, 32'd2);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        rsp_ready = 1'b0;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'd2);
        chk("bp_valid_low", 32'(rsp_valid), 32'd0);
        chk("bp_op_count", 32'(op_count), exp_cnt);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset pulse while in EXEC discards the operation
        do_reset();
        @(negedge clk);
        req_a[31:0] = 32'd1;
        req_b[31:0] = 32'd1;
        req_op[3:0] = ALU_ADD;
        req_valid   = 4'b0001;
        #1;
        chk("mr_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mr_busy_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(rsp_valid), 32'd0);
        chk("mr_result", rsp_result, 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("mr_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
        end
        chk("mr_op_count", 32'(op_count), 32'd0);

        // Counter wrap on the 3-bit instance: eighth handshake returns it to 0
        for (int i = 0; i < 8; i++)
            run_op(32'(i % 4), 32'(i), 32'd1, ALU_ADD, 32'(i + 1), 1'b0, 1'b0);
        chk("wrap_small", 32'(op_count_w), 32'd0);
        chk("wrap_main", 32'(op_count), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
